// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, branch redirect sequencing, wrong-path
// invalidation, stall/flush performance counters and a stall watchdog.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  input  logic             perf_clr_i,
  output logic [5:0]       stall,
  output logic             pc_redirect_o,
  output logic [31:0]      new_pc_o,
  output logic             next_inst_invalid_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             stall_timeout_o
);

  localparam int unsigned   RunW    = $clog2(TIMEOUT + 1);
  localparam logic [RunW-1:0] RunMax  = RunW'(TIMEOUT);
  localparam logic [RunW-1:0] RunLast = RunW'(TIMEOUT - 1);

  typedef enum logic {StIdle, StPend} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             timeout_q, timeout_d;
  logic             accept;
  logic             pend_valid;

  // Stall vector: the highest requesting stage freezes itself and everything upstream.
  always_comb begin
    stall = 6'b000000;
    if (stallreq_from_mem)     stall = 6'b011111;
    else if (stallreq_from_ex) stall = 6'b001111;
    else if (stallreq_from_id) stall = 6'b000111;
    else if (stallreq_from_if) stall = 6'b000011;
  end

  // Redirect FSM next state; a stalled ID re-presents its branch, so it is ignored here.
  always_comb begin
    accept     = branch_flag_i & ~stall[2];
    pend_valid = (state_q == StPend);
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    if (accept) begin
      state_d   = StPend;
      pend_pc_d = branch_target_i;
    end else if (pend_valid && !stall[0]) begin
      state_d = StIdle;
    end
  end

  // Counters and watchdog next state; perf_clr_i leaves the watchdog alone.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    run_cnt_d      = run_cnt_q;
    timeout_d      = timeout_q;
    if (perf_clr_i) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else begin
      if (stall[0] && (stall_cycles_q != {CNT_W{1'b1}})) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (accept && (flush_count_q != {CNT_W{1'b1}})) begin
        flush_count_d = flush_count_q + CNT_W'(1);
      end
    end
    if (!stall[0]) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != RunMax) begin
      run_cnt_d = run_cnt_q + RunW'(1);
    end
    if (stall[0] && (run_cnt_q == RunLast)) begin
      timeout_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pend_pc_q      <= '0;
      run_cnt_q      <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_pc_q      <= pend_pc_d;
      run_cnt_q      <= run_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      timeout_q      <= timeout_d;
    end
  end

  // Outputs: the pending redirect is held until PC is free to take it.
  always_comb begin
    pc_redirect_o       = pend_valid & ~stall[0];
    new_pc_o            = pend_pc_q;
    next_inst_invalid_o = accept | pend_valid;
    stall_cycles_o      = stall_cycles_q;
    flush_count_o       = flush_count_q;
    stall_timeout_o     = timeout_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog timeout.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic        branch;
  logic [31:0] target;
  logic        perf_clr;
  logic [5:0]  stall;
  logic        redirect;
  logic [31:0] new_pc;
  logic        invalid;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl #(.TIMEOUT(8), .CNT_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stallreq_from_if    (req_if),
    .stallreq_from_id    (req_id),
    .stallreq_from_ex    (req_ex),
    .stallreq_from_mem   (req_mem),
    .branch_flag_i       (branch),
    .branch_target_i     (target),
    .perf_clr_i          (perf_clr),
    .stall               (stall),
    .pc_redirect_o       (redirect),
    .new_pc_o            (new_pc),
    .next_inst_invalid_o (invalid),
    .stall_cycles_o      (stall_cycles),
    .flush_count_o       (flush_count),
    .stall_timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {req_if, req_id, req_ex, req_mem, branch, perf_clr} = '0;
    target = '0;
    tick();
    tick();
    chk("rst_stall", {26'd0, stall}, 32'h0);
    chk("rst_redirect", {31'd0, redirect}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_invalid", {31'd0, invalid}, 32'h0);
    chk("rst_stall_cycles", stall_cycles, 32'h0);
    chk("rst_flush", flush_count, 32'h0);
    chk("rst_timeout", {31'd0, timeout}, 32'h0);
    rst = 1'b0;

    // Priority, all within one cycle so nothing is counted at the edge.
    tick();
    req_id = 1'b1; req_mem = 1'b1; #1;
    chk("prio_id_mem", {26'd0, stall}, 32'h1f);
    req_mem = 1'b0; #1;
    chk("prio_id", {26'd0, stall}, 32'h07);
    req_id = 1'b0; req_if = 1'b1; #1;
    chk("prio_if", {26'd0, stall}, 32'h03);
    req_if = 1'b0; req_ex = 1'b1; #1;
    chk("prio_ex", {26'd0, stall}, 32'h0f);
    req_ex = 1'b0; #1;
    chk("prio_none", {26'd0, stall}, 32'h00);

    // Branch with no stall.
    tick();
    branch = 1'b1; target = 32'h100; #1;
    chk("br_n_invalid", {31'd0, invalid}, 32'h1);
    chk("br_n_redirect", {31'd0, redirect}, 32'h0);
    tick();
    branch = 1'b0; #1;
    chk("br_n1_redirect", {31'd0, redirect}, 32'h1);
    chk("br_n1_new_pc", new_pc, 32'h100);
    chk("br_n1_invalid", {31'd0, invalid}, 32'h1);
    tick();
    chk("br_n2_redirect", {31'd0, redirect}, 32'h0);
    chk("br_n2_flush", flush_count, 32'h1);
    chk("br_n2_invalid", {31'd0, invalid}, 32'h0);

    // Branch accepted under a 3-cycle fetch stall.
    tick();
    req_if = 1'b1; branch = 1'b1; target = 32'h80; #1;
    chk("bs_n_invalid", {31'd0, invalid}, 32'h1);
    tick();
    branch = 1'b0; #1;
    chk("bs_n1_redirect", {31'd0, redirect}, 32'h0);
    chk("bs_n1_invalid", {31'd0, invalid}, 32'h1);
    tick();
    chk("bs_n2_redirect", {31'd0, redirect}, 32'h0);
    chk("bs_n2_invalid", {31'd0, invalid}, 32'h1);
    tick();
    req_if = 1'b0; #1;
    chk("bs_n3_redirect", {31'd0, redirect}, 32'h1);
    chk("bs_n3_new_pc", new_pc, 32'h80);
    chk("bs_n3_invalid", {31'd0, invalid}, 32'h1);
    chk("bs_n3_stall_cycles", stall_cycles, 32'd3);
    tick();
    chk("bs_n4_redirect", {31'd0, redirect}, 32'h0);
    chk("bs_n4_flush", flush_count, 32'd2);

    // Branch while ID stalls is ignored.
    tick();
    req_id = 1'b1; branch = 1'b1; target = 32'h300; #1;
    chk("ign_stall", {26'd0, stall}, 32'h07);
    chk("ign_invalid", {31'd0, invalid}, 32'h0);
    tick();
    req_id = 1'b0; branch = 1'b0; #1;
    chk("ign_redirect", {31'd0, redirect}, 32'h0);
    chk("ign_invalid_after", {31'd0, invalid}, 32'h0);
    chk("ign_flush", flush_count, 32'd2);
    chk("ign_stall_cycles", stall_cycles, 32'd4);

    // Performance counter clear.
    tick();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0; #1;
    chk("clr_stall_cycles", stall_cycles, 32'd0);
    chk("clr_flush", flush_count, 32'd0);

    // Watchdog: 7 stalled cycles do not trip it.
    req_ex = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    req_ex = 1'b0; #1;
    chk("wd7_timeout", {31'd0, timeout}, 32'h0);
    chk("wd7_stall_cycles", stall_cycles, 32'd7);
    // 8 stalled cycles trip it on the following cycle.
    tick();
    req_ex = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("wd8_before", {31'd0, timeout}, 32'h0);
    tick();
    req_ex = 1'b0; #1;
    chk("wd8_timeout", {31'd0, timeout}, 32'h1);
    chk("wd8_stall_cycles", stall_cycles, 32'd15);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    tick();
    chk("wd_sticky", {31'd0, timeout}, 32'h1);
    chk("wd_clr_stall_cycles", stall_cycles, 32'd0);

    // Reset while a redirect to 0x200 is pending.
    branch = 1'b1; target = 32'h200;
    tick();
    branch = 1'b0; #1;
    chk("pre_rst_redirect", {31'd0, redirect}, 32'h1);
    chk("pre_rst_new_pc", new_pc, 32'h200);
    chk("pre_rst_flush", flush_count, 32'd1);
    rst = 1'b1; #1;
    chk("arst_stall", {26'd0, stall}, 32'h0);
    chk("arst_redirect", {31'd0, redirect}, 32'h0);
    chk("arst_new_pc", new_pc, 32'h0);
    chk("arst_invalid", {31'd0, invalid}, 32'h0);
    chk("arst_flush", flush_count, 32'h0);
    chk("arst_stall_cycles", stall_cycles, 32'h0);
    chk("arst_timeout", {31'd0, timeout}, 32'h0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_redirect", {31'd0, redirect}, 32'h0);
    chk("post_rst_invalid", {31'd0, invalid}, 32'h0);
    tick();
    chk("post_rst_redirect2", {31'd0, redirect}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
